// File: rtl/axi_gpio_pwm_mc.sv
// AXI4-Lite slave with GPIO output, synchronized GPIO input, rising-edge interrupts
// and PWM_CH PWM channels whose period/duty shadows load into the active copies at wrap.
module axi_gpio_pwm_mc #(
   parameter int unsigned GPIO_W = 8,
   parameter int unsigned PWM_CH = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              ACLK,
   input  logic              ARESET_N,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       WDATA,
   input  logic [3:0]        WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [PWM_CH-1:0] pwm_out,
   output logic              irq
);

   logic              awready_q, bvalid_q, arready_q, rvalid_q, irq_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [31:0]       rdata_q;
   logic [GPIO_W-1:0] gpio_out_q, irq_en_q, irq_stat_q, sync1_q, sync2_q, sync3_q;
   logic [PWM_CH-1:0] pwm_en_q, pwm_q;
   logic [CNT_W-1:0]  per_sh_q [PWM_CH];
   logic [CNT_W-1:0]  duty_sh_q [PWM_CH];
   logic [CNT_W-1:0]  per_act_q [PWM_CH];
   logic [CNT_W-1:0]  duty_act_q [PWM_CH];
   logic [CNT_W-1:0]  cnt_q [PWM_CH];

   logic              wr_en, rd_en, wr_err, rd_err;
   logic [31:0]       wmask, wsel, rsel, rd_val;
   logic [GPIO_W-1:0] gpio_out_d, irq_en_d, irq_stat_d, w1c;
   logic [PWM_CH-1:0] pwm_en_d;
   logic [CNT_W-1:0]  per_sh_d [PWM_CH];
   logic [CNT_W-1:0]  duty_sh_d [PWM_CH];
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [31:0] mask);
      return (old & ~mask) | (data & mask);
   endfunction

   assign wr_en = awready_q && AWVALID && WVALID;
   assign rd_en = arready_q && ARVALID;
   assign wsel  = 32'(AWADDR[ADDR_W-1:2]);
   assign rsel  = 32'(ARADDR[ADDR_W-1:2]);

   // Shadow next-state values feed both the shadow registers and the wrap-time load (bypass)
   always_comb begin
      for (int unsigned b = 0; b < 4; b++) wmask[8*b +: 8] = {8{WSTRB[b]}};
      gpio_out_d = gpio_out_q;
      pwm_en_d   = pwm_en_q;
      irq_en_d   = irq_en_q;
      w1c        = '0;
      wr_err     = 1'b1;
      for (int unsigned k = 0; k < PWM_CH; k++) begin
         per_sh_d[k]  = per_sh_q[k];
         duty_sh_d[k] = duty_sh_q[k];
      end
      if (wr_en) begin
         case (wsel)
            32'd0: begin
               wr_err     = 1'b0;
               gpio_out_d = GPIO_W'(merge(32'(gpio_out_q), WDATA, wmask));
            end
            32'd2: begin
               wr_err   = 1'b0;
               pwm_en_d = PWM_CH'(merge(32'(pwm_en_q), WDATA, wmask));
            end
            32'd3: begin
               wr_err   = 1'b0;
               irq_en_d = GPIO_W'(merge(32'(irq_en_q), WDATA, wmask));
            end
            32'd4: begin
               wr_err = 1'b0;
               w1c    = GPIO_W'(WDATA & wmask);
            end
            default: begin
               for (int unsigned k = 0; k < PWM_CH; k++) begin
                  if (wsel == 8 + 2*k) begin
                     wr_err      = 1'b0;
                     per_sh_d[k] = CNT_W'(merge(32'(per_sh_q[k]), WDATA, wmask));
                  end
                  if (wsel == 9 + 2*k) begin
                     wr_err       = 1'b0;
                     duty_sh_d[k] = CNT_W'(merge(32'(duty_sh_q[k]), WDATA, wmask));
                  end
               end
            end
         endcase
      end
      irq_stat_d = (irq_stat_q & ~w1c) | (sync2_q & ~sync3_q);
   end

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      case (rsel)
         32'd0: rd_val = 32'(gpio_out_q);
         32'd1: rd_val = 32'(sync2_q);
         32'd2: rd_val = 32'(pwm_en_q);
         32'd3: rd_val = 32'(irq_en_q);
         32'd4: rd_val = 32'(irq_stat_q);
         default: begin
            rd_err = 1'b1;
            for (int unsigned k = 0; k < PWM_CH; k++) begin
               if (rsel == 8 + 2*k) begin
                  rd_err = 1'b0;
                  rd_val = 32'(per_sh_q[k]);
               end
               if (rsel == 9 + 2*k) begin
                  rd_err = 1'b0;
                  rd_val = 32'(duty_sh_q[k]);
               end
            end
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
      end else begin
         awready_q <= AWVALID && WVALID && !bvalid_q && !awready_q;
         arready_q <= ARVALID && !rvalid_q && !arready_q;
         if (wr_en) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? 2'b10 : 2'b00;
         end else if (BREADY) begin
            bvalid_q <= 1'b0;
         end
         if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err ? '0 : rd_val;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
         end else if (RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         gpio_out_q <= '0;
         irq_en_q   <= '0;
         irq_stat_q <= '0;
         pwm_en_q   <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         irq_en_q   <= irq_en_d;
         irq_stat_q <= irq_stat_d;
         pwm_en_q   <= pwm_en_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         irq_q      <= |(irq_stat_q & irq_en_q);
      end
   end

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         pwm_q <= '0;
         for (int unsigned k = 0; k < PWM_CH; k++) begin
            per_sh_q[k]   <= '0;
            duty_sh_q[k]  <= '0;
            per_act_q[k]  <= '0;
            duty_act_q[k] <= '0;
            cnt_q[k]      <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < PWM_CH; k++) begin
            per_sh_q[k]  <= per_sh_d[k];
            duty_sh_q[k] <= duty_sh_d[k];
            if (!pwm_en_q[k] || per_act_q[k] == '0) begin
               cnt_q[k]      <= '0;
               pwm_q[k]      <= 1'b0;
               per_act_q[k]  <= per_sh_d[k];
               duty_act_q[k] <= duty_sh_d[k];
            end else begin
               pwm_q[k] <= cnt_q[k] < duty_act_q[k];
               if (cnt_q[k] == per_act_q[k] - CNT_W'(1)) begin
                  cnt_q[k]      <= '0;
                  per_act_q[k]  <= per_sh_d[k];
                  duty_act_q[k] <= duty_sh_d[k];
               end else begin
                  cnt_q[k] <= cnt_q[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   assign AWREADY  = awready_q;
   assign WREADY   = awready_q;
   assign BVALID   = bvalid_q;
   assign BRESP    = bresp_q;
   assign ARREADY  = arready_q;
   assign RVALID   = rvalid_q;
   assign RDATA    = rdata_q;
   assign RRESP    = rresp_q;
   assign gpio_out = gpio_out_q;
   assign pwm_out  = pwm_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_axi_gpio_pwm_mc.sv
// Directed + randomized bench for axi_gpio_pwm_mc: register model for the bus map,
// waveform-shape checks for PWM, directed interrupt and handshake scenarios.
module tb_axi_gpio_pwm_mc;
   localparam int unsigned GPIO_W = 8;
   localparam int unsigned PWM_CH = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ADDR_W = 7;

   logic              ACLK = 1'b0;
   logic              ARESET_N;
   logic [ADDR_W-1:0] AWADDR, ARADDR;
   logic              AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [31:0]       WDATA, RDATA;
   logic [3:0]        WSTRB;
   logic              AWREADY, WREADY, BVALID, ARREADY, RVALID, irq;
   logic [1:0]        BRESP, RRESP;
   logic [GPIO_W-1:0] gpio_in, gpio_out;
   logic [PWM_CH-1:0] pwm_out;

   always #5 ACLK = ~ACLK;

   axi_gpio_pwm_mc #(.GPIO_W(GPIO_W), .PWM_CH(PWM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .ACLK(ACLK), .ARESET_N(ARESET_N),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .pwm_out(pwm_out), .irq(irq)
   );

   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_reg [11];
   logic        hist[$];
   logic        rec = 1'b0;

   // Channel-0 waveform history, one sample per cycle
   always @(posedge ACLK) begin
      #1;
      if (rec) hist.push_back(pwm_out[0]);
   end

   function automatic logic [6:0] reg_addr(input int i);
      if (i == 0) return 7'h00;
      if (i == 1) return 7'h08;
      if (i == 2) return 7'h0C;
      return 7'(32 + 8*((i-3)/2) + 4*((i-3)%2));
   endfunction

   function automatic logic [31:0] reg_mask(input int i);
      if (i == 0 || i == 2) return 32'hFF;
      if (i == 1) return 32'hF;
      return 32'hFFFF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      tests++;
      fails++;
      $error("FAIL %s: timeout, got no response expected handshake", tag);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      resp = 2'bxx;
      @(negedge ACLK);
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!AWREADY && n < 20);
      if (!AWREADY) begin
         AWVALID = 1'b0; WVALID = 1'b0;
         timeout_fail("aw_accept");
         return;
      end
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0;
      n = 0;
      while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
      if (!BVALID) begin timeout_fail("b_valid"); return; end
      resp = BRESP;
      if (BREADY) @(negedge ACLK);
   endtask

   task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      d = 'x; resp = 2'bxx;
      @(negedge ACLK);
      ARADDR = a; ARVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!ARREADY && n < 20);
      if (!ARREADY) begin ARVALID = 1'b0; timeout_fail("ar_accept"); return; end
      @(negedge ACLK);
      ARVALID = 1'b0;
      n = 0;
      while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
      if (!RVALID) begin timeout_fail("r_valid"); return; end
      d = RDATA; resp = RRESP;
      if (RREADY) @(negedge ACLK);
   endtask

   task automatic wait_rise(input int ch, input int bound, output bit ok);
      logic prev;
      ok = 1'b0;
      @(negedge ACLK);
      prev = pwm_out[ch];
      for (int i = 0; i < bound; i++) begin
         @(negedge ACLK);
         if (pwm_out[ch] && !prev) begin ok = 1'b1; return; end
         prev = pwm_out[ch];
      end
   endtask

   task automatic sample_pwm(input int ch, input int n, output logic [31:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge ACLK);
         v[i] = pwm_out[ch];
      end
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] d, v, e, bm;
      logic [29:0] hv, he;
      bit          ok, seen;
      int          i, j, p, du, n, base;

      ARESET_N = 1'b0;
      AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      BREADY = 1'b1; RREADY = 1'b1; gpio_in = '0;
      for (int k = 0; k < 11; k++) m_reg[k] = '0;

      cycles(3);
      check("rst_ready", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
      check("rst_valid", 32'({BVALID, RVALID}), 32'd0);
      check("rst_gpio_out", 32'(gpio_out), 32'd0);
      check("rst_pwm_irq", 32'({pwm_out, irq}), 32'd0);
      ARESET_N = 1'b1;
      cycles(2);

      // Reset in the middle of an accepted-but-unanswered write and read
      @(negedge ACLK);
      AWADDR = 7'h00; WDATA = 32'h33; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 7'h00; ARVALID = 1'b1;
      @(negedge ACLK);
      check("midrst_aw_pending", 32'({AWREADY, ARREADY}), 32'd3);
      ARESET_N = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      @(negedge ACLK);
      check("midrst_flags", 32'({AWREADY, BVALID, ARREADY, RVALID}), 32'd0);
      check("midrst_gpio_out", 32'(gpio_out), 32'd0);
      ARESET_N = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge ACLK);
         if (BVALID || RVALID) seen = 1'b1;
      end
      check("midrst_no_stale", 32'(seen), 32'd0);

      axi_write(7'h00, 32'hAA, 4'hF, r);
      m_reg[0] = 32'hAA;
      check("gpio_wr_bresp", 32'(r), 32'd0);
      @(negedge ACLK);
      check("gpio_out_port", 32'(gpio_out), 32'hAA);
      axi_read(7'h00, d, r);
      check("gpio_rd_data", d, 32'hAA);
      check("gpio_rd_rresp", 32'(r), 32'd0);

      // Random byte-strobed writes with random low address bits, read back against model
      for (int it = 0; it < 24; it++) begin
         i = $urandom_range(0, 10);
         d = $urandom;
         WSTRB = 4'($urandom_range(0, 15));
         bm = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};
         axi_write(reg_addr(i) | 7'($urandom_range(0, 3)), d, WSTRB, r);
         check("rnd_bresp", 32'(r), 32'd0);
         m_reg[i] = ((m_reg[i] & ~bm) | (d & bm)) & reg_mask(i);
         j = $urandom_range(0, 10);
         axi_read(reg_addr(j) | 7'($urandom_range(0, 3)), v, r);
         check("rnd_rdata", v, m_reg[j]);
         check("rnd_rresp", 32'(r), 32'd0);
         check("rnd_gpio_out", 32'(gpio_out), m_reg[0]);
      end
      axi_write(7'h08, 32'h0, 4'hF, r);
      m_reg[1] = 32'h0;

      // Unmapped and read-only accesses
      axi_write(7'h7C, 32'hFFFF_FFFF, 4'hF, r);
      check("wr_7c_bresp", 32'(r), 32'd2);
      axi_write(7'h04, 32'hFFFF_FFFF, 4'hF, r);
      check("wr_ro_bresp", 32'(r), 32'd2);
      axi_write(7'h14, 32'hFFFF_FFFF, 4'hF, r);
      check("wr_14_bresp", 32'(r), 32'd2);
      axi_write(7'h0C, 32'hFFFF_FFFF, 4'h0, r);
      check("wr_nostrb_bresp", 32'(r), 32'd0);
      for (int k = 0; k < 11; k++) begin
         axi_read(reg_addr(k), v, r);
         check("nochange_rdata", v, m_reg[k]);
      end
      axi_read(7'h7C, v, r);
      check("rd_7c_rdata", v, 32'd0);
      check("rd_7c_rresp", 32'(r), 32'd2);

      // Response held while the master stalls
      BREADY = 1'b0;
      axi_write(7'h00, 32'h55, 4'hF, r);
      m_reg[0] = 32'h55;
      check("stall_bresp", 32'(r), 32'd0);
      AWADDR = 7'h0C; WDATA = 32'hFF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ok = 1'b1;
      repeat (5) begin
         @(negedge ACLK);
         if (!(BVALID && BRESP == 2'b00 && !AWREADY && !WREADY)) ok = 1'b0;
      end
      check("stall_b_hold", 32'(ok), 32'd1);
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
      @(negedge ACLK);
      check("stall_b_release", 32'(BVALID), 32'd0);
      axi_read(7'h0C, v, r);
      check("stall_no_2nd_write", v, m_reg[2]);
      RREADY = 1'b0;
      axi_read(7'h00, v, r);
      check("stall_rdata", v, 32'h55);
      ARADDR = 7'h08; ARVALID = 1'b1;
      ok = 1'b1;
      repeat (5) begin
         @(negedge ACLK);
         if (!(RVALID && RDATA == 32'h55 && RRESP == 2'b00 && !ARREADY)) ok = 1'b0;
      end
      check("stall_r_hold", 32'(ok), 32'd1);
      ARVALID = 1'b0; RREADY = 1'b1;
      @(negedge ACLK);
      check("stall_r_release", 32'(RVALID), 32'd0);

      // Interrupts
      axi_write(7'h0C, 32'h0, 4'hF, r);
      m_reg[2] = 32'h0;
      gpio_in[1] = 1'b1;
      cycles(5);
      axi_read(7'h10, v, r);
      check("stat_without_en", v, 32'h02);
      check("irq_masked", 32'(irq), 32'd0);
      axi_read(7'h04, v, r);
      check("gpio_in_read", v, 32'h02);
      axi_write(7'h10, 32'h02, 4'hF, r);
      axi_read(7'h10, v, r);
      check("stat_w1c", v, 32'h00);
      axi_write(7'h0C, 32'h01, 4'hF, r);
      m_reg[2] = 32'h01;
      @(negedge ACLK);
      gpio_in[0] = 1'b1;
      n = 0;
      while (!irq && n < 6) begin @(negedge ACLK); n++; end
      if (!irq) timeout_fail("irq_rise");
      else check("irq_latency_ok", 32'(n <= 4), 32'd1);
      axi_read(7'h10, v, r);
      check("stat_bit0", v, 32'h01);
      axi_write(7'h10, 32'h01, 4'hF, r);
      cycles(2);
      check("irq_cleared", 32'(irq), 32'd0);
      gpio_in[0] = 1'b0;
      cycles(5);
      gpio_in[0] = 1'b1;
      cycles(5);
      gpio_in[0] = 1'b0;
      cycles(5);
      gpio_in[0] = 1'b1;
      axi_write(7'h10, 32'h01, 4'hF, r);
      cycles(2);
      axi_read(7'h10, v, r);
      check("stat_set_wins", v, 32'h01);
      check("irq_set_wins", 32'(irq), 32'd1);

      // Channel 0: 3/7 then duty changed mid-period to 8
      axi_write(7'h20, 32'd10, 4'hF, r);
      axi_write(7'h24, 32'd3, 4'hF, r);
      axi_write(7'h08, 32'h1, 4'hF, r);
      m_reg[3] = 32'd10; m_reg[4] = 32'd3; m_reg[1] = 32'h1;
      rec = 1'b1;
      wait_rise(0, 30, ok);
      if (!ok) begin
         timeout_fail("ch0_rise");
      end else begin
         base = hist.size() - 1;
         axi_write(7'h24, 32'd8, 4'hF, r);
         m_reg[4] = 32'd8;
         cycles(34);
         for (int k = 0; k < 30; k++) begin
            hv[k] = hist[base + k];
            he[k] = ((k % 10) < ((k < 10) ? 3 : 8));
         end
         check("ch0_duty_change", 32'(hv), 32'(he));
      end
      rec = 1'b0;

      // Channel 1: duty beyond period, then period 0
      axi_write(7'h2C, 32'd20, 4'hF, r);
      axi_write(7'h28, 32'd10, 4'hF, r);
      axi_write(7'h08, 32'h3, 4'hF, r);
      cycles(12);
      sample_pwm(1, 15, v);
      check("ch1_const_high", v, 32'h7FFF);
      axi_write(7'h28, 32'd0, 4'hF, r);
      cycles(14);
      sample_pwm(1, 15, v);
      check("ch1_period0_low", v, 32'h0);

      // Channel 2: random period/duty, waveform shape
      for (int it = 0; it < 8; it++) begin
         p  = $urandom_range(1, 12);
         du = $urandom_range(0, 15);
         axi_write(7'h08, 32'h0, 4'hF, r);
         axi_write(7'h30, 32'(p), 4'hF, r);
         axi_write(7'h34, 32'(du), 4'hF, r);
         axi_write(7'h08, 32'h4, 4'hF, r);
         if (du == 0 || du >= p) begin
            cycles(p + 4);
            n = 2*p + 4;
            sample_pwm(2, n, v);
            e = (du == 0) ? 32'h0 : ((32'h1 << n) - 32'h1);
            check("ch2_constant", v, e);
         end else begin
            wait_rise(2, 2*p + 6, ok);
            if (!ok) begin
               timeout_fail("ch2_rise");
            end else begin
               v = '0; e = '0;
               v[0] = pwm_out[2];
               e[0] = 1'b1;
               for (int k = 1; k < 2*p; k++) begin
                  @(negedge ACLK);
                  v[k] = pwm_out[2];
                  e[k] = ((k % p) < du);
               end
               check("ch2_shape", v, e);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
